gray_count_checker: RTL
=======================

Name: gray_count_checker

Overview:
- Downstream consumer of the gray-code counter output.
- Registers each gray sample and converts it to binary.
- Checks that every transition is a legal hold or a single step.
- Counts and flags violations, so a corrupted or badly sampled counter is caught before its value is used as a pointer or timestamp.

Parameters:
DATA_WIDTH, 4, width of gray input and binary output
CNT_WIDTH, 8, width of saturating error counter
ALLOW_DOWN, 0, 1 = a -1 step (binary delta all-ones) is also legal

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of error state; re-arms reference capture
in_valid  input  1  in_gray is sampled this cycle
in_gray  input  DATA_WIDTH  gray-coded counter value
out_valid  output  1  out_* fields valid this cycle
out_bin  output  DATA_WIDTH  binary equivalent of accepted sample
out_step  output  1  sample advanced by exactly +1 (including wrap)
out_err  output  1  single-cycle pulse: illegal transition on this sample
err_sticky  output  1  set on first error, held until clr or reset
err_cnt  output  CNT_WIDTH  number of illegal transitions, saturating

Behaviour:
- Reset (resetn low, asynchronous): every output goes to 0 and the FSM goes to INIT. Internal prev_bin is 0.
- Conversion: bin[i] = XOR of in_gray[DATA_WIDTH-1:i]. bin[MSB] = gray[MSB].
- Latency: a sample accepted at edge t shows on out_* after edge t, i.e. one cycle. out_valid is the registered in_valid. out_bin holds its last value when out_valid = 0.
- Delta rule: delta = bin - prev_bin, modulo 2^DATA_WIDTH.
  - Legal: delta = 0 (hold) or delta = 1 (step).
  - Wrap is legal: all-ones to 0 gives delta = 1.
  - If ALLOW_DOWN = 1, delta = all-ones is also legal; out_step stays 0 for it.
  - Any other delta is illegal.
- FSM:
  - INIT: the first valid sample is the reference. It is output with out_valid = 1, out_step = 0, out_err = 0, and the FSM moves to TRACK.
  - TRACK: each valid sample is checked. Legal: out_step = (delta == 1). Illegal: out_err = 1, err_sticky is set, err_cnt increments, and the FSM stays in TRACK.
  - prev_bin is updated on every valid sample, including illegal ones, so one glitch gives at most two errors, not a cascade.
- err_cnt saturates at 2^CNT_WIDTH - 1. It never wraps.
- clr:
  - Next cycle: err_cnt = 0, err_sticky = 0, out_err = 0, out_valid = 0, FSM = INIT.
  - clr has priority over in_valid in the same cycle; that sample is dropped (no output, not used as reference).
- in_valid = 0: no state change. out_step and out_err are 0.
- Reset mid-operation: immediate return to reset values. The first sample after reset is a reference and is never flagged.

Optional Feature:
- Macro: GRAY_COUNT_CHECKER_SYNC_EN.
- Defined:
  - in_gray passes through a 2-flop synchronizer before conversion, for a counter in an unrelated clock domain.
  - in_valid is delayed through a matching 2-flop pipe.
  - Total latency becomes 3 cycles.
  - Synchronizer flops reset to 0 asynchronously.
  - clr also flushes the valid pipe, so samples in flight at clr are dropped.
- Undefined: no synchronizer; latency is 1 cycle as above.

Test Plan:
- Reset, then valid gray 0,1,3,2,6,7,5,4 on consecutive cycles -> out_bin 0..7 one cycle later; out_step = 0 on the first sample, 1 after; out_err never set.
- Full wrap, DATA_WIDTH = 4: gray 4'b1000 then 4'b0000 -> out_bin 15 then 0, out_step = 1, no error.
- Jump: gray 0 then 4'b0010 (bin 3) -> out_err pulse, err_sticky = 1, err_cnt = 1. Next gray 4'b0110 (bin 4) -> legal step, err_cnt stays 1.
- CNT_WIDTH = 2, five illegal jumps -> err_cnt = 3 (saturated). Then clr together with a valid sample -> err_cnt = 0, err_sticky = 0, sample dropped, next sample taken as reference with no error.
- ALLOW_DOWN = 0: bin 5 -> 4 flags an error. ALLOW_DOWN = 1: same sequence gives no error and out_step = 0.
- Assert resetn low mid-stream with err_sticky = 1 -> all outputs 0 immediately. Resume at arbitrary gray 4'b1100 -> no error flagged. With GRAY_COUNT_CHECKER_SYNC_EN, output appears 3 cycles after the input.

Source files
------------

// File: rtl/gray_count_checker.sv
// -----------------------------------------------------------------------------
// gray_count_checker
//
// Purpose:
//   Consumer-side monitor for a gray-code counter. Each accepted gray sample is
//   registered, converted to binary and compared with the previously accepted
//   value. A legal transition is a hold (delta 0) or a single step (delta +1,
//   including the all-ones -> 0 wrap). Optionally a single down step
//   (delta all-ones) is also legal. Illegal transitions raise a one-cycle
//   error pulse, a sticky flag and a saturating error count. This catches a
//   corrupted or badly sampled counter before its value is used as a pointer
//   or timestamp.
//
// Parameters:
//   DATA_WIDTH : width of the gray input and the binary output
//   CNT_WIDTH  : width of the saturating error counter
//   ALLOW_DOWN : 1 = a -1 step is also a legal transition (out_step stays 0)
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   clr        in   synchronous clear of the error state; re-arms reference
//   in_valid   in   in_gray is sampled this cycle
//   in_gray    in   gray-coded counter value
//   out_valid  out  out_* fields valid this cycle (registered in_valid)
//   out_bin    out  binary value of the last accepted sample (held otherwise)
//   out_step   out  accepted sample advanced by exactly +1
//   out_err    out  one-cycle pulse: illegal transition on this sample
//   err_sticky out  set on the first error, held until clr or reset
//   err_cnt    out  number of illegal transitions, saturating
//
// Optional feature (macro GRAY_COUNT_CHECKER_SYNC_EN):
//   When defined, in_gray goes through a 2-flop synchronizer and in_valid
//   through a matching 2-flop pipe, so the counter may live in an unrelated
//   clock domain. Latency becomes 3 cycles. clr flushes the valid pipe, so
//   samples in flight at clr are dropped. When undefined, latency is 1 cycle.
// -----------------------------------------------------------------------------
module gray_count_checker #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int ALLOW_DOWN = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_gray,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_bin,
    output logic                  out_step,
    output logic                  out_err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   prev_bin;

    logic                    samp_valid;
    logic [DATA_WIDTH-1:0]   samp_gray;
    logic [DATA_WIDTH-1:0]   samp_bin;
    logic [DATA_WIDTH-1:0]   delta;
    logic                    is_hold;
    logic                    is_step;
    logic                    is_down;
    logic                    is_legal;

`ifdef GRAY_COUNT_CHECKER_SYNC_EN
    logic [DATA_WIDTH-1:0]   gray_meta;
    logic [DATA_WIDTH-1:0]   gray_sync;
    logic                    valid_meta;
    logic                    valid_sync;

    // Two-flop synchronizer for the gray bus plus a matching valid pipe.
    // Gray coding guarantees at most one bit changes per source step, so the
    // synchronized word is always either the old or the new value. clr
    // empties the valid pipe so nothing captured before clr reaches the FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gray_meta  <= '0;
            gray_sync  <= '0;
            valid_meta <= 1'b0;
            valid_sync <= 1'b0;
        end else begin
            gray_meta <= in_gray;
            gray_sync <= gray_meta;
            if (clr) begin
                valid_meta <= 1'b0;
                valid_sync <= 1'b0;
            end else begin
                valid_meta <= in_valid;
                valid_sync <= valid_meta;
            end
        end
    end

    assign samp_gray  = gray_sync;
    assign samp_valid = valid_sync;
`else
    assign samp_gray  = in_gray;
    assign samp_valid = in_valid;
`endif

    // Gray to binary: each binary bit is the XOR of all gray bits at or above
    // it, computed as a running XOR from the MSB down.
    always_comb begin
        samp_bin = '0;
        samp_bin[DATA_WIDTH-1] = samp_gray[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            samp_bin[i] = samp_bin[i+1] ^ samp_gray[i];
        end
    end

    // Modulo-2^DATA_WIDTH difference makes the all-ones -> 0 wrap a +1 step.
    assign delta    = samp_bin - prev_bin;
    assign is_hold  = (delta == '0);
    assign is_step  = (delta == DATA_WIDTH'(1));
    assign is_down  = (ALLOW_DOWN != 0) && (delta == '1);
    assign is_legal = is_hold || is_step || is_down;

    // Checker FSM with registered outputs. clr wins over a sample in the same
    // cycle and re-arms reference capture. prev_bin follows every accepted
    // sample, legal or not, so a single corrupted value costs at most two
    // errors instead of flagging everything after it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_INIT;
            prev_bin   <= '0;
            out_valid  <= 1'b0;
            out_bin    <= '0;
            out_step   <= 1'b0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            state      <= ST_INIT;
            out_valid  <= 1'b0;
            out_step   <= 1'b0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid <= samp_valid;
            out_step  <= 1'b0;
            out_err   <= 1'b0;
            if (samp_valid) begin
                out_bin  <= samp_bin;
                prev_bin <= samp_bin;
                case (state)
                    ST_INIT: begin
                        state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (is_legal) begin
                            out_step <= is_step;
                        end else begin
                            out_err    <= 1'b1;
                            err_sticky <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_INIT;
                    end
                endcase
            end
        end
    end

endmodule
